// File: rtl/suprloco_rom_loader.sv
// ioctl ROM download receiver: splits the flat ROM image into per-chip regions and
// forwards each byte to the board memory arbiter over a req/ack handshake.
module suprloco_rom_loader #(
    parameter logic [15:0] ROM_INDEX = 16'h0000,
    parameter logic [26:0] R0_END    = 27'h0C000,
    parameter logic [26:0] R1_END    = 27'h0E000,
    parameter logic [26:0] R2_END    = 27'h14000,
    parameter logic [26:0] R3_END    = 27'h1C000,
    parameter logic [26:0] R4_END    = 27'h1C200
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_INITRST,
    input  logic [15:0] ioctl_index,
    input  logic        ioctl_download,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic        o_MEM_REQ,
    output logic [2:0]  o_MEM_REGION,
    output logic [16:0] o_MEM_ADDR,
    output logic [7:0]  o_MEM_DATA,
    input  logic        i_MEM_ACK,
    output logic        o_LOADING,
    output logic        o_LOADED,
    output logic        o_OVERFLOW
);

    localparam int NUM_REGIONS = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [26:0]            region_end  [NUM_REGIONS];
    logic [16:0]            region_base [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] below_end;

    logic [2:0]  hit_region;
    logic [16:0] hit_offset;
    logic        in_range;

    logic        active;
    logic        active_prev_reg;
    logic        active_rise;
    logic        start;
    logic        accept;

    logic [2:0]  region_reg;
    logic [16:0] offset_reg;
    logic [7:0]  data_reg;
    logic        loaded_reg;
    logic        overflow_reg;

    assign region_end[0] = R0_END;
    assign region_end[1] = R1_END;
    assign region_end[2] = R2_END;
    assign region_end[3] = R3_END;
    assign region_end[4] = R4_END;

    // Regions are contiguous: each base is the previous region's end. Offsets only
    // need 17 bits, so the subtraction is done modulo 2^17 on the low bits.
    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            if (gi == 0) begin : g_first
                assign region_base[gi] = '0;
            end else begin : g_rest
                assign region_base[gi] = region_end[gi-1][16:0];
            end
            assign below_end[gi] = (ioctl_addr < region_end[gi]);
        end
    endgenerate

    // Lowest region whose end lies above the address wins.
    always_comb begin
        hit_region = 3'd0;
        hit_offset = 17'd0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (below_end[i]) begin
                hit_region = 3'(i);
                hit_offset = ioctl_addr[16:0] - region_base[i];
            end
        end
    end

    assign in_range    = |below_end;
    assign active      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign active_rise = active && !active_prev_reg;
    assign start       = active_rise && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    // ioctl_wait is low in RECV, so a strobe there is always a legal byte.
    assign accept      = (state_reg == ST_RECV) && ioctl_wr;

    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (accept && in_range) begin
                    state_next = ST_WRITE;
                end else if (!active) begin
                    state_next = ST_DONE;
                end
            end
            ST_WRITE: begin
                // A download that ended mid-write finishes the handshake before completing.
                if (i_MEM_ACK) begin
                    state_next = active ? ST_RECV : ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = start ? ST_RECV : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ioctl_wait   = (state_reg == ST_WRITE);
        o_MEM_REQ    = (state_reg == ST_WRITE);
        o_LOADING    = (state_reg == ST_RECV) || (state_reg == ST_WRITE);
        o_MEM_REGION = region_reg;
        o_MEM_ADDR   = offset_reg;
        o_MEM_DATA   = data_reg;
        o_LOADED     = loaded_reg;
        o_OVERFLOW   = overflow_reg;
    end

    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            active_prev_reg <= 1'b0;
            region_reg      <= 3'd0;
            offset_reg      <= 17'd0;
            data_reg        <= 8'd0;
            loaded_reg      <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            active_prev_reg <= active;
            if (accept && in_range) begin
                region_reg <= hit_region;
                offset_reg <= hit_offset;
                data_reg   <= ioctl_data;
            end
            if (start) begin
                loaded_reg   <= 1'b0;
                overflow_reg <= 1'b0;
            end else begin
                if ((state_next == ST_DONE) && (state_reg != ST_DONE)) begin
                    loaded_reg <= 1'b1;
                end
                if (accept && !in_range) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_suprloco_rom_loader.sv
// Directed bench for suprloco_rom_loader with a region-map model, write scoreboard
// and a per-cycle handshake monitor.
module tb_suprloco_rom_loader;

    localparam int R4_LIMIT = 'h1C200;

    typedef struct {
        int region;
        int offset;
        int data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic [15:0] ioctl_index;
    logic        ioctl_download;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic        o_MEM_REQ;
    logic [2:0]  o_MEM_REGION;
    logic [16:0] o_MEM_ADDR;
    logic [7:0]  o_MEM_DATA;
    logic        i_MEM_ACK;
    logic        o_LOADING;
    logic        o_LOADED;
    logic        o_OVERFLOW;

    int vectors    = 0;
    int miscompares = 0;
    int write_count = 0;
    int fixed_delay = 0;
    bit rand_ack    = 0;
    bit model_active = 0;

    wr_t        exp_q[$];
    wr_t        seen_q[$];
    logic [7:0] mem [int];

    suprloco_rom_loader dut (
        .i_EMU_MCLK    (clk),
        .i_EMU_INITRST (rst),
        .ioctl_index   (ioctl_index),
        .ioctl_download(ioctl_download),
        .ioctl_addr    (ioctl_addr),
        .ioctl_data    (ioctl_data),
        .ioctl_wr      (ioctl_wr),
        .ioctl_wait    (ioctl_wait),
        .o_MEM_REQ     (o_MEM_REQ),
        .o_MEM_REGION  (o_MEM_REGION),
        .o_MEM_ADDR    (o_MEM_ADDR),
        .o_MEM_DATA    (o_MEM_DATA),
        .i_MEM_ACK     (i_MEM_ACK),
        .o_LOADING     (o_LOADING),
        .o_LOADED      (o_LOADED),
        .o_OVERFLOW    (o_OVERFLOW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Memory map of the ROM image: region index and in-region offset for a flat address.
    function automatic void model_decode(input int a, output int r, output int off);
        int ends [5];
        int base;
        ends = '{'h0C000, 'h0E000, 'h14000, 'h1C000, 'h1C200};
        r    = 7;
        off  = 0;
        base = 0;
        for (int i = 0; i < 5; i++) begin
            if (r == 7 && a < ends[i]) begin
                r   = i;
                off = a - base;
            end
            base = ends[i];
        end
    endfunction

    function automatic logic [7:0] image_byte(input int a);
        return 8'(a ^ (a >> 8) ^ 'h5A);
    endfunction

    // Arbiter: acks after a programmable number of cycles with REQ high.
    initial begin
        int cnt;
        int cur;
        cnt = 0;
        cur = 0;
        i_MEM_ACK = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                i_MEM_ACK = 1'b0;
                cnt = 0;
            end else if (i_MEM_ACK) begin
                i_MEM_ACK = 1'b0;
                cnt = 0;
            end else if (o_MEM_REQ) begin
                if (cnt == 0) cur = rand_ack ? int'($urandom_range(0, 7)) : fixed_delay;
                if (cnt >= cur) i_MEM_ACK = 1'b1;
                else cnt++;
            end
        end
    end

    // Per-cycle monitor: wait/req coincidence, request stability, scoreboard on handshakes.
    initial begin
        bit          prev_hold;
        logic [27:0] prev_fields;
        wr_t         e;
        wr_t         s;
        prev_hold = 1'b0;
        prev_fields = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_hold = 1'b0;
                continue;
            end
            check("wait_eq_req", {31'd0, ioctl_wait}, {31'd0, o_MEM_REQ});
            if (prev_hold) begin
                check("req_held", {31'd0, o_MEM_REQ}, 32'd1);
                check("fields_held", {4'd0, o_MEM_REGION, o_MEM_ADDR, o_MEM_DATA}, {4'd0, prev_fields});
            end
            if (o_MEM_REQ && i_MEM_ACK) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got region %0d addr %h data %h required no write",
                             o_MEM_REGION, o_MEM_ADDR, o_MEM_DATA);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_region", {29'd0, o_MEM_REGION}, e.region);
                    check("wr_addr", {15'd0, o_MEM_ADDR}, e.offset);
                    check("wr_data", {24'd0, o_MEM_DATA}, e.data);
                end
                mem[int'(o_MEM_REGION) * 'h20000 + int'(o_MEM_ADDR)] = o_MEM_DATA;
                s.region = int'(o_MEM_REGION);
                s.offset = int'(o_MEM_ADDR);
                s.data   = int'(o_MEM_DATA);
                seen_q.push_back(s);
                write_count++;
            end
            prev_hold   = o_MEM_REQ && !i_MEM_ACK;
            prev_fields = {o_MEM_REGION, o_MEM_ADDR, o_MEM_DATA};
        end
    end

    task automatic send_byte(input int a, input logic [7:0] d);
        int  g;
        wr_t e;
        g = 0;
        @(negedge clk);
        while (ioctl_wait && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got wait stuck high required wait low");
        end
        ioctl_addr = 27'(a);
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        if (model_active && a < R4_LIMIT) begin
            model_decode(a, e.region, e.offset);
            e.data = int'(d);
            exp_q.push_back(e);
        end
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_download(input logic [15:0] idx);
        @(negedge clk);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        model_active   = (idx == 16'h0000);
        repeat (2) @(negedge clk);
    endtask

    task automatic end_download(input bit expect_loaded);
        int g;
        @(negedge clk);
        ioctl_download = 1'b0;
        model_active   = 1'b0;
        g = 0;
        #2;
        while (expect_loaded && !o_LOADED && g < 50) begin
            @(negedge clk);
            #2;
            g++;
        end
        repeat (3) @(negedge clk);
        #2;
        check("loaded_at_end", {31'd0, o_LOADED}, {31'd0, expect_loaded});
        check("loading_at_end", {31'd0, o_LOADING}, 32'd0);
    endtask

    task automatic count_wait(output int n);
        int g;
        g = 0;
        n = 0;
        #2;
        while (ioctl_wait && g < 200) begin
            n++;
            @(negedge clk);
            #2;
            g++;
        end
    endtask

    initial begin
        int n;
        int base_wc;
        int r;
        int off;
        int addrs[$];
        int ends [5];
        int starts [5];

        rst = 1'b1;
        ioctl_index = 16'h0000;
        ioctl_download = 1'b0;
        ioctl_addr = '0;
        ioctl_data = '0;
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", {31'd0, o_MEM_REQ}, 32'd0);
        check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
        check("rst_loaded", {31'd0, o_LOADED}, 32'd0);
        check("rst_overflow", {31'd0, o_OVERFLOW}, 32'd0);
        check("rst_loading", {31'd0, o_LOADING}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single byte, ack after 3 cycles
        fixed_delay = 3;
        start_download(16'h0000);
        #1;
        check("t1_loading", {31'd0, o_LOADING}, 32'd1);
        base_wc = write_count;
        send_byte('h10, 8'hA5);
        #1;
        check("t1_wait_up", {31'd0, ioctl_wait}, 32'd1);
        check("t1_req", {31'd0, o_MEM_REQ}, 32'd1);
        check("t1_region", {29'd0, o_MEM_REGION}, 32'd0);
        check("t1_addr", {15'd0, o_MEM_ADDR}, 32'h10);
        check("t1_data", {24'd0, o_MEM_DATA}, 32'hA5);
        count_wait(n);
        check("t1_wait_cycles", n, 4);
        check("t1_write_count", write_count - base_wc, 1);
        end_download(1'b1);

        // 2: region boundaries
        fixed_delay = 1;
        start_download(16'h0000);
        send_byte('h0BFFF, 8'h11);
        send_byte('h0C000, 8'h22);
        send_byte('h1C1FF, 8'h33);
        end_download(1'b1);
        n = seen_q.size();
        check("t2_r0", seen_q[n-3].region, 0);
        check("t2_o0", seen_q[n-3].offset, 'hBFFF);
        check("t2_r1", seen_q[n-2].region, 1);
        check("t2_o1", seen_q[n-2].offset, 'h0000);
        check("t2_r4", seen_q[n-1].region, 4);
        check("t2_o4", seen_q[n-1].offset, 'h01FF);
        check("t2_d4", seen_q[n-1].data, 'h33);

        // 3: out-of-range byte
        start_download(16'h0000);
        #1;
        check("t3_loaded_cleared", {31'd0, o_LOADED}, 32'd0);
        send_byte('h1C200, 8'h44);
        #1;
        check("t3_wait", {31'd0, ioctl_wait}, 32'd0);
        check("t3_req", {31'd0, o_MEM_REQ}, 32'd0);
        check("t3_overflow", {31'd0, o_OVERFLOW}, 32'd1);
        end_download(1'b1);
        check("t3_overflow_sticky", {31'd0, o_OVERFLOW}, 32'd1);
        start_download(16'h0000);
        #1;
        check("t3_overflow_cleared", {31'd0, o_OVERFLOW}, 32'd0);
        end_download(1'b1);

        // 4: foreign index is ignored
        base_wc = write_count;
        start_download(16'h0001);
        for (int i = 0; i < 6; i++) begin
            send_byte(i * 'h5000, 8'(i));
            #1;
            check("t4_wait", {31'd0, ioctl_wait}, 32'd0);
        end
        check("t4_loading", {31'd0, o_LOADING}, 32'd0);
        end_download(1'b1);
        check("t4_writes", write_count - base_wc, 0);
        ioctl_index = 16'h0000;

        // 5: download ends while ack withheld for 10 cycles
        fixed_delay = 10;
        start_download(16'h0000);
        send_byte('h0D000, 8'h5C);
        ioctl_download = 1'b0;
        model_active = 1'b0;
        begin
            int g;
            g = 0;
            n = 0;
            #2;
            while (o_MEM_REQ && g < 200) begin
                n++;
                check("t5_loaded_early", {31'd0, o_LOADED}, 32'd0);
                @(negedge clk);
                #2;
                g++;
            end
        end
        check("t5_wait_cycles", n, 11);
        check("t5_loaded", {31'd0, o_LOADED}, 32'd1);
        check("t5_loading", {31'd0, o_LOADING}, 32'd0);
        repeat (3) @(negedge clk);

        // 6: reset during a write, then a sparse full-map download with random ack delay
        fixed_delay = 5;
        start_download(16'h0000);
        send_byte('h100, 8'h77);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_req", {31'd0, o_MEM_REQ}, 32'd0);
        check("t6_rst_wait", {31'd0, ioctl_wait}, 32'd0);
        check("t6_rst_loaded", {31'd0, o_LOADED}, 32'd0);
        exp_q.delete();
        ioctl_download = 1'b0;
        model_active = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t6_loaded_after_rst", {31'd0, o_LOADED}, 32'd0);

        ends   = '{'h0C000, 'h0E000, 'h14000, 'h1C000, 'h1C200};
        starts = '{0, 'h0C000, 'h0E000, 'h14000, 'h1C000};
        for (int ri = 0; ri < 5; ri++) begin
            for (int k = 0; k < 16; k++) addrs.push_back(starts[ri] + k);
            for (int a = starts[ri] + 'h400; a < ends[ri] - 16; a += 'h400) addrs.push_back(a);
            for (int k = 16; k > 0; k--) addrs.push_back(ends[ri] - k);
        end
        mem.delete();
        write_count = 0;
        rand_ack = 1'b1;
        start_download(16'h0000);
        foreach (addrs[i]) send_byte(addrs[i], image_byte(addrs[i]));
        end_download(1'b1);
        check("t6_write_count", write_count, addrs.size());
        check("t6_queue_empty", exp_q.size(), 0);
        foreach (addrs[i]) begin
            model_decode(addrs[i], r, off);
            check("t6_image", {24'd0, mem[r * 'h20000 + off]}, {24'd0, image_byte(addrs[i])});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
